pressure_controller: RTL
========================

PRESSURE_CONTROLLER -- requirements
Module: pressure_controller

Interface
REQ-001 The block SHALL have parameter PRESS_CYCLES, default 8: number of active pump cycles needed to go from low to high chamber pressure.
REQ-002 The block SHALL have parameter DEPRESS_CYCLES, default 5: number of active pump cycles needed to go from high to low chamber pressure.
REQ-003 The block SHALL have parameter CNT_W, default 4: width of the cycle counter; PRESS_CYCLES and DEPRESS_CYCLES SHALL each lie in 1..2^CNT_W-1.
REQ-004 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-005 The port list SHALL be, clock and reset first:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- startPressurizing  input  1  request to pump the chamber up to high pressure
- startDepressurizing  input  1  request to pump the chamber down to low pressure
- odClosed  input  1  outer door closed
- idClosed  input  1  inner door closed
- isHighPressure  output  1  chamber at high pressure
- pumpOn  output  1  pump running this cycle
- pumpDir  output  1  1 = pressurizing, 0 = depressurizing
- pressureDone  output  1  one-cycle completion pulse
- remaining  output  CNT_W  active pump cycles left; 0 when idle

Function
REQ-006 The block SHALL implement four states:
- HIGH: idle at high pressure
- LOW: idle at low pressure
- PRESS: pumping up
- DEPRESS: pumping down
REQ-007 In HIGH, when startDepressurizing=1 and startPressurizing=0 at a rising edge, the block SHALL enter DEPRESS and load remaining=DEPRESS_CYCLES on that edge.
REQ-008 In LOW, when startPressurizing=1 and startDepressurizing=0 at a rising edge, the block SHALL enter PRESS and load remaining=PRESS_CYCLES on that edge.
REQ-009 In HIGH or LOW, the block SHALL ignore the following, with no state change and no pressureDone:
- a request for the pressure already held
- both requests asserted together
REQ-010 In PRESS or DEPRESS, the block SHALL ignore both request inputs.
REQ-011 In PRESS or DEPRESS, when odClosed=1 and idClosed=1 at a rising edge:
- remaining>1: remaining SHALL decrement by 1
- remaining=1: the block SHALL enter HIGH (from PRESS) or LOW (from DEPRESS) and set remaining=0
REQ-012 In PRESS or DEPRESS, when either door input is 0 at a rising edge, remaining and state SHALL hold (pause).
REQ-013 The block SHALL accept a request regardless of door state; with a door open, it enters PRESS or DEPRESS paused.
REQ-014 Outputs SHALL be Moore-style, derived from registered state:
- pumpOn=1 only in PRESS/DEPRESS with odClosed&idClosed=1; door inputs SHALL gate pumpOn combinationally.
- pumpDir=1 in PRESS, 0 in all other states.
- isHighPressure=1 only in HIGH; 0 in PRESS, DEPRESS and LOW.
REQ-015 pressureDone SHALL be a registered pulse, high for exactly the one cycle following the edge that enters HIGH or LOW from PRESS or DEPRESS.
REQ-016 Latency SHALL be as follows, with doors closed throughout and a request sampled at edge k:
- pumpOn high for exactly N cycles (N = PRESS_CYCLES or DEPRESS_CYCLES)
- the new idle state is entered at edge k+N
- each paused cycle adds exactly one cycle of latency
REQ-017 remaining SHALL never underflow or wrap; it SHALL be 0 in HIGH and LOW.

Reset
REQ-018 While reset=1, independent of clock, the block SHALL force:
- state HIGH
- isHighPressure=1
- pumpOn=0, pumpDir=0
- pressureDone=0
- remaining=0
REQ-019 Reset asserted in any state, including mid-pump, SHALL abandon the operation with no pressureDone pulse.
REQ-020 On the first rising edge after reset deasserts, the block SHALL evaluate inputs normally from HIGH.

Verification
REQ-021 Reset: reset=1 with arbitrary inputs -> isHighPressure=1, pumpOn=0, pumpDir=0, pressureDone=0, remaining=0 immediately, without a clock edge.
REQ-022 Depressurize: doors closed, startDepressurizing pulsed at edge k:
- remaining reads 5,4,3,2,1 after edges k..k+4
- pumpOn=1 and pumpDir=0 for those 5 cycles
- after edge k+5: LOW, isHighPressure=0, remaining=0, pressureDone=1 for one cycle
REQ-023 Pause: in PRESS from LOW, odClosed=0 for 3 cycles while remaining=6:
- remaining holds 6 and pumpOn=0 during those cycles
- total latency 11 cycles
- then HIGH with isHighPressure=1 and a single pressureDone pulse
REQ-024 Conflicts: in HIGH, apply each of the following and confirm no state change, pumpOn=0 and pressureDone=0:
- both requests together
- startPressurizing alone
- either request issued during DEPRESS
REQ-025 Reset mid-operation: reset asserted in DEPRESS with remaining=3 -> HIGH, remaining=0, pumpOn=0 immediately; no pressureDone pulse at any point.

Source files
------------

// File: rtl/pressure_controller.sv
// Airlock chamber pressure controller.
//
// Sequences a pump between two idle pressure states. A request moves the
// chamber from HIGH to LOW (DEPRESS) or LOW to HIGH (PRESS); the pump then
// needs a fixed number of active cycles, and it is only active while both
// doors are closed. An open door pauses the count. Completion raises a
// one-cycle pressureDone pulse.
//
// Ports:
//   clock               rising-edge clock
//   reset               asynchronous, active-high; returns to HIGH
//   startPressurizing   request LOW -> HIGH
//   startDepressurizing request HIGH -> LOW
//   odClosed, idClosed  outer / inner door closed
//   isHighPressure      chamber idle at high pressure
//   pumpOn              pump running this cycle (gated by doors)
//   pumpDir             1 = pressurizing, 0 = depressurizing
//   pressureDone        one-cycle pulse after reaching the new idle state
//   remaining           active pump cycles left, 0 when idle
//
// PRESS_CYCLES and DEPRESS_CYCLES must lie in 1..2^CNT_W-1.
module pressure_controller #(
    parameter int PRESS_CYCLES   = 8,
    parameter int DEPRESS_CYCLES = 5,
    parameter int CNT_W          = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             startPressurizing,
    input  logic             startDepressurizing,
    input  logic             odClosed,
    input  logic             idClosed,
    output logic             isHighPressure,
    output logic             pumpOn,
    output logic             pumpDir,
    output logic             pressureDone,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        HIGH    = 2'd0,
        LOW     = 2'd1,
        PRESS   = 2'd2,
        DEPRESS = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES);
    localparam logic [CNT_W-1:0] DEPRESS_LOAD = CNT_W'(DEPRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             done, done_next;
    logic             doors_closed;
    logic             pumping;

    assign doors_closed = odClosed & idClosed;
    assign pumping      = (state == PRESS) || (state == DEPRESS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= HIGH;
            count <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            done  <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        done_next  = 1'b0;
        unique case (state)
            HIGH: begin
                // Simultaneous requests are ambiguous and ignored.
                if (startDepressurizing && !startPressurizing) begin
                    state_next = DEPRESS;
                    count_next = DEPRESS_LOAD;
                end
            end
            LOW: begin
                if (startPressurizing && !startDepressurizing) begin
                    state_next = PRESS;
                    count_next = PRESS_LOAD;
                end
            end
            PRESS, DEPRESS: begin
                // Requests are ignored while pumping; an open door freezes
                // both count and state.
                if (doors_closed) begin
                    if (count == CNT_ONE) begin
                        state_next = (state == PRESS) ? HIGH : LOW;
                        count_next = '0;
                        done_next  = 1'b1;
                    end else begin
                        count_next = count - CNT_ONE;
                    end
                end
            end
            default: begin
                state_next = HIGH;
                count_next = '0;
            end
        endcase
    end

    // Door inputs gate the pump combinationally so an opened door stops it
    // in the same cycle rather than one edge later.
    assign pumpOn         = pumping && doors_closed;
    assign pumpDir        = (state == PRESS);
    assign isHighPressure = (state == HIGH);
    assign pressureDone   = done;
    assign remaining      = count;

endmodule
